piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width; legal values are WIDTH >= 2.
REQ-002 Port clk, input, 1 bit: clock; all state SHALL update on the rising edge.
REQ-003 Port rst, input, 1 bit: reset; it SHALL be asynchronous and active-low.
REQ-004 Port p_in, input, WIDTH bits: parallel word to serialize.
REQ-005 Port p_valid, input, 1 bit: p_in holds a valid word.
REQ-006 Port p_ready, output, 1 bit: the block can accept a word this cycle.
REQ-007 Port s_out, output, 1 bit: serial data, LSB first.
REQ-008 Port s_en, output, 1 bit: s_out carries a valid bit this cycle; a downstream serial-in/parallel-out stage SHALL use ~s_en as its shift(0)/load(1) mode.
REQ-009 Port word_done, output, 1 bit: one-cycle pulse after the last bit of a word.
REQ-010 Port busy, output, 1 bit: a word is held or being shifted.

Function
REQ-011 Internal state SHALL be: shift register sh[WIDTH]; bit counter cnt of max(1, ceil(log2 WIDTH)) bits; holding register hold[WIDTH] with flag hold_vld; FSM state in {IDLE, SHIFT, DONE}.
REQ-012 p_ready SHALL equal !hold_vld, driven directly from the register with no combinational path from p_valid.
REQ-013 A word SHALL be accepted at a rising edge only when p_valid=1 and p_ready=1; on acceptance hold<=p_in and hold_vld<=1.
REQ-014 If p_valid=1 while p_ready=0, the word SHALL NOT be captured; the source SHALL hold p_in stable until acceptance.
REQ-015 IDLE with hold_vld=1: on the next edge sh<=hold, cnt<=0, hold_vld<=0, state<=SHIFT.
REQ-016 IDLE with hold_vld=0: the FSM SHALL remain in IDLE.
REQ-017 SHIFT: s_out=sh[0] and s_en=1; on each edge sh<=sh>>1 with the MSB filled with 0, and cnt<=cnt+1.
REQ-018 SHIFT with cnt==WIDTH-1: the next edge SHALL move to DONE, so s_en is high for exactly WIDTH cycles.
REQ-019 DONE lasts exactly one cycle with word_done=1 and s_en=0.
REQ-020 DONE: the next edge SHALL load from hold into SHIFT (as REQ-015) if hold_vld=1, otherwise go to IDLE.
REQ-021 Same-edge transfer and acceptance (hold emptied into sh while p_valid=1): p_ready is already 0, so acceptance is impossible; the new word SHALL be accepted on the following edge.
REQ-022 Latency from an accepting edge N with the FSM in IDLE: first bit valid after edge N+1; last bit after edge N+WIDTH; word_done after edge N+WIDTH+1.
REQ-023 Back-to-back throughput SHALL be one word per WIDTH+1 cycles; the single DONE gap cycle is the downstream load cycle.
REQ-024 s_out SHALL be 0 whenever s_en=0.
REQ-025 busy SHALL equal (state!=IDLE) || hold_vld.
REQ-026 All outputs SHALL be derived from registers only (no input-to-output combinational paths).

Reset
REQ-027 While rst=0, independent of clk: state=IDLE, sh=0, cnt=0, hold=0, hold_vld=0.
REQ-028 While rst=0, outputs SHALL be s_out=0, s_en=0, word_done=0, busy=0, p_ready=1.
REQ-029 Reset asserted mid-word SHALL discard the shifting word and any held word; no word_done pulse SHALL be issued for either.
REQ-030 After reset release, the first rising edge SHALL behave as IDLE.

Verification
REQ-031 Reset: assert rst=0 at t=0, release at 10 -> all outputs at reset values; p_ready=1; busy=0.
REQ-032 Single word, WIDTH=4: p_in=4'b1001 accepted at edge N -> s_en=1 after edges N+1..N+4 with s_out=1,0,0,1; word_done=1 after edge N+5 only; a downstream SIPO driven by mode=~s_en yields p_out=1001.
REQ-033 Back-to-back: A=0110, then B=1100 with p_valid held high -> B accepted one edge after A; p_ready=0 until B is moved to sh; serial stream is 0,1,1,0,(gap),0,0,1,1; exactly two word_done pulses, WIDTH+1 cycles apart.
REQ-034 Stall: third word C presented while hold is full -> p_ready=0 and C is not captured until hold empties; C is then emitted intact with no duplicate or lost word.
REQ-035 Reset mid-shift: rst=0 after 2 bits of 4'b1011 with 4'b0101 held -> s_en=0, busy=0, and p_ready=1 immediately; no word_done; after release the block stays in IDLE until new input.
REQ-036 WIDTH=8: p_in=8'hA5 -> s_out=1,0,1,0,0,1,0,1 over 8 s_en cycles, then one word_done pulse.

Source files
------------

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with a one-word holding register.
// Streams LSB first; a one-cycle DONE gap separates words for the downstream load.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic             s_out,
    output logic             s_en,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH <= 2) ? 1 : $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    cnt;
    logic             hold_vld;
    logic             accept;
    logic             load;

    // Acceptance depends only on the registered flag, so a load and an
    // acceptance can never happen on the same edge.
    assign accept = p_valid && !hold_vld;
    assign load   = hold_vld && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            hold     <= '0;
            hold_vld <= 1'b0;
        end else begin
            if (accept) begin
                hold     <= p_in;
                hold_vld <= 1'b1;
            end else if (load) begin
                hold_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (hold_vld) begin
                        sh    <= hold;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh  <= {1'b0, sh[WIDTH-1:1]};
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (hold_vld) begin
                        sh    <= hold;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode registers only; s_out is gated so it reads 0 outside SHIFT.
    assign p_ready   = !hold_vld;
    assign s_en      = (state == SHIFT);
    assign s_out     = (state == SHIFT) && sh[0];
    assign word_done = (state == DONE);
    assign busy      = (state != IDLE) || hold_vld;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: table-driven single words, directed corner
// sequences, and a randomized run against a timeline reference model.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] p_in4;
    logic       p_valid4;
    logic       p_ready4, s_out4, s_en4, word_done4, busy4;
    logic [7:0] p_in8;
    logic       p_valid8;
    logic       p_ready8, s_out8, s_en8, word_done8, busy8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .p_in(p_in4), .p_valid(p_valid4),
        .p_ready(p_ready4), .s_out(s_out4), .s_en(s_en4),
        .word_done(word_done4), .busy(busy4)
    );

    piso_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .p_in(p_in8), .p_valid(p_valid8),
        .p_ready(p_ready8), .s_out(s_out8), .s_en(s_en8),
        .word_done(word_done8), .busy(busy8)
    );

    typedef struct {
        logic [3:0] word;
        logic [3:0] stream;   // serial bits in time order, first bit leftmost
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic single4(input logic [3:0] word, input logic [3:0] stream);
        logic [3:0] sipo;
        sipo = '0;
        @(negedge clk);
        chk("w4_ready_before", p_ready4, 1);
        p_in4 = word;
        p_valid4 = 1'b1;
        @(negedge clk);
        p_valid4 = 1'b0;
        chk("w4_accept_busy", busy4, 1);
        chk("w4_accept_sen", s_en4, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w4_bit_sen", s_en4, 1);
            chk("w4_bit_val", s_out4, stream[3-i]);
            chk("w4_bit_nodone", word_done4, 0);
            if (!s_en4 == 1'b0) sipo = {s_out4, sipo[3:1]};
        end
        @(negedge clk);
        chk("w4_done_pulse", word_done4, 1);
        chk("w4_done_sen", s_en4, 0);
        chk("w4_done_sout", s_out4, 0);
        chk("w4_sipo_word", sipo, word);
        @(negedge clk);
        chk("w4_after_done", word_done4, 0);
        chk("w4_after_busy", busy4, 0);
        $display("single w4 word=%b done", word);
    endtask

    task automatic single8(input logic [7:0] word, input logic [7:0] stream);
        @(negedge clk);
        p_in8 = word;
        p_valid8 = 1'b1;
        @(negedge clk);
        p_valid8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("w8_bit_sen", s_en8, 1);
            chk("w8_bit_val", s_out8, stream[7-i]);
            chk("w8_bit_nodone", word_done8, 0);
        end
        @(negedge clk);
        chk("w8_done_pulse", word_done8, 1);
        chk("w8_done_sen", s_en8, 0);
        @(negedge clk);
        chk("w8_after_done", word_done8, 0);
        chk("w8_after_busy", busy8, 0);
        $display("single w8 word=%h done", word);
    endtask

    // Back-to-back A,B then stalled C, driven by a source that honours p_ready.
    task automatic b2b_stall();
        logic [3:0] src_q[$];
        logic [31:0] bits;
        int nbits;
        int done_at[$];
        logic rdy_tr[32];
        bit pending;
        src_q = '{4'b0110, 4'b1100, 4'b1010};
        bits = '0;
        nbits = 0;
        pending = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            if (s_en4) begin
                bits[nbits] = s_out4;
                nbits++;
            end
            if (word_done4) done_at.push_back(c);
            rdy_tr[c] = p_ready4;
            if (pending) void'(src_q.pop_front());
            pending = 0;
            if (src_q.size() > 0) begin
                p_in4 = src_q[0];
                p_valid4 = 1'b1;
                pending = p_ready4;
            end else begin
                p_valid4 = 1'b0;
            end
        end
        chk("b2b_nbits", nbits, 12);
        chk("b2b_stream", bits[11:0], 12'b1010_1100_0110);
        chk("b2b_ndone", done_at.size(), 3);
        if (done_at.size() == 3) begin
            chk("b2b_done_a", done_at[0], 6);
            chk("b2b_done_gap_ab", done_at[1] - done_at[0], 5);
            chk("b2b_done_gap_bc", done_at[2] - done_at[1], 5);
        end
        chk("b2b_rdy_after_a", rdy_tr[1], 0);
        chk("b2b_rdy_xfer_a", rdy_tr[2], 1);
        chk("b2b_rdy_after_b", rdy_tr[3], 0);
        chk("stall_rdy_held", rdy_tr[6], 0);
        chk("stall_rdy_xfer_b", rdy_tr[7], 1);
        chk("stall_rdy_after_c", rdy_tr[8], 0);
        $display("b2b/stall sequence: %0d bits, %0d word_done pulses", nbits, done_at.size());
    endtask

    task automatic reset_mid_shift();
        @(negedge clk);
        p_in4 = 4'b1011;
        p_valid4 = 1'b1;
        @(negedge clk);
        chk("rms_busy", busy4, 1);
        chk("rms_rdy_full", p_ready4, 0);
        p_in4 = 4'b0101;
        @(negedge clk);
        chk("rms_bit0", s_out4, 1);
        chk("rms_rdy_xfer", p_ready4, 1);
        @(negedge clk);
        chk("rms_bit1", s_out4, 1);
        chk("rms_held", p_ready4, 0);
        p_valid4 = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("rms_sen", s_en4, 0);
        chk("rms_sout", s_out4, 0);
        chk("rms_busy0", busy4, 0);
        chk("rms_rdy1", p_ready4, 1);
        chk("rms_done0", word_done4, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rms_post_sen", s_en4, 0);
            chk("rms_post_done", word_done4, 0);
            chk("rms_post_busy", busy4, 0);
        end
        $display("reset mid-shift sequence done");
    endtask

    // Reference timeline: each accepted word is loaded at
    // max(accept+1, previous load + WIDTH+1) and then occupies fixed slots.
    bit exp_en[1024], exp_out[1024], exp_done[1024], exp_busy[1024], exp_rdy[1024];

    task automatic random4(input int ncyc);
        int prev_l;
        int e, l;
        bit held;
        int accepted;
        for (int i = 0; i < 1024; i++) begin
            exp_en[i] = 0; exp_out[i] = 0; exp_done[i] = 0;
            exp_busy[i] = 0; exp_rdy[i] = 1;
        end
        prev_l = -100;
        held = 0;
        accepted = 0;
        p_valid4 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < ncyc + 16; k++) begin
            if (k > 0) @(negedge clk);
            chk("rnd_sen", s_en4, exp_en[k]);
            chk("rnd_sout", s_out4, exp_out[k]);
            chk("rnd_done", word_done4, exp_done[k]);
            chk("rnd_busy", busy4, exp_busy[k]);
            chk("rnd_rdy", p_ready4, exp_rdy[k]);
            if (!held) begin
                if (k < ncyc) begin
                    p_valid4 = ($urandom_range(0, 2) != 0);
                    p_in4 = 4'($urandom);
                end else begin
                    p_valid4 = 1'b0;
                end
            end
            if (p_valid4 && exp_rdy[k]) begin
                e = k + 1;
                l = (e + 1 > prev_l + 5) ? e + 1 : prev_l + 5;
                for (int i = 0; i < 4; i++) begin
                    exp_en[l+i] = 1;
                    exp_out[l+i] = p_in4[i];
                end
                exp_done[l+4] = 1;
                for (int j = e; j < l; j++) begin
                    exp_busy[j] = 1;
                    exp_rdy[j] = 0;
                end
                for (int j = l; j <= l + 4; j++) exp_busy[j] = 1;
                prev_l = l;
                held = 0;
                accepted++;
            end else begin
                held = p_valid4;
            end
        end
        $display("random run: %0d cycles, %0d words accepted", ncyc + 16, accepted);
    endtask

    initial begin
        vecs[0] = '{word: 4'b1001, stream: 4'b1001};
        vecs[1] = '{word: 4'b0110, stream: 4'b0110};
        vecs[2] = '{word: 4'b1100, stream: 4'b0011};
        vecs[3] = '{word: 4'b1011, stream: 4'b1101};
        vecs[4] = '{word: 4'b1111, stream: 4'b1111};
        vecs[5] = '{word: 4'b0001, stream: 4'b1000};

        rst = 1'b0;
        p_in4 = '0; p_valid4 = 1'b0;
        p_in8 = '0; p_valid8 = 1'b0;
        #1;
        chk("rst_sen", s_en4, 0);
        chk("rst_sout", s_out4, 0);
        chk("rst_done", word_done4, 0);
        chk("rst_busy", busy4, 0);
        chk("rst_rdy", p_ready4, 1);
        chk("rst_rdy8", p_ready8, 1);
        #9 rst = 1'b1;
        #2;
        chk("rel_rdy", p_ready4, 1);
        chk("rel_busy", busy4, 0);
        $display("reset checks done");

        for (int i = 0; i < 6; i++) single4(vecs[i].word, vecs[i].stream);
        single8(8'hA5, 8'b1010_0101);
        single8(8'h01, 8'b1000_0000);
        b2b_stall();
        reset_mid_shift();
        random4(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
